laser_scan_sched: RTL and testbench

Sequencing controller for the LASER coverage datapath. After the object store is loaded, it walks every candidate circle centre in serpentine order over `MAX_ITER` refinement passes. For each candidate it issues object batches to the shared `PARALLEL`-wide inside-evaluator bank through a valid/ready handshake, then tells the best-candidate tracker when to compare and when a pass ends. It sits between the object loader (which supplies `START`) and the evaluator/tracker pair.

---
 rtl/laser_pkg.sv | 30 +++
 rtl/laser_scan_ptr.sv | 43 ++++
 rtl/laser_scan_sched.sv | 119 +++++++++++
 tb/tb_laser_scan_sched.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and sizing for the LASER coverage datapath.
// Imported by the scan scheduler and its pointer sub-module.
package laser_pkg;

    localparam int OBJ_NUM   = 40;
    localparam int PARALLEL  = 4;
    localparam int NUM_BATCH = (OBJ_NUM + PARALLEL - 1) / PARALLEL;
    localparam int MAX_ITER  = 6;

    localparam int BATCH_W = 4;
    localparam int ITER_W  = 3;
    localparam int DRAIN_W = 8;

    typedef logic [3:0] coord_t;

    typedef struct packed {
        coord_t y;
        coord_t x;
    } ptr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CMP,
        S_NEXT,
        S_FINISH
    } state_t;

endpackage

// File: rtl/laser_scan_ptr.sv
// Serpentine candidate pointer, pass counter and endpoint detection.
// Even passes count up, odd passes count down; a pass endpoint is held.
module laser_scan_ptr
    import laser_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              step,
    input  logic              restart,
    output ptr_t              ptr,
    output logic [ITER_W-1:0] iter,
    output logic              at_end,
    output logic              last_iter
);

    logic down;

    assign down = iter[0];

    always_comb begin
        at_end    = down ? (ptr == 8'h00) : (ptr == 8'hFF);
        last_iter = (iter == ITER_W'(MAX_ITER - 1));
    end

    // The endpoint is revisited as the first candidate of the next pass.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr  <= '0;
            iter <= '0;
        end else if (restart) begin
            ptr  <= '0;
            iter <= '0;
        end else if (step) begin
            if (at_end) begin
                if (!last_iter)
                    iter <= iter + 1'b1;
            end else begin
                ptr <= down ? ptr_t'(ptr - 8'd1) : ptr_t'(ptr + 8'd1);
            end
        end
    end

endmodule

// File: rtl/laser_scan_sched.sv
// Candidate scan sequencer: issues object batches per candidate centre,
// then drives the tracker compare / pass-end strobes.
module laser_scan_sched
    import laser_pkg::*;
#(
    parameter int RES_LAT = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               ABORT,
    output logic               BUSY,
    output logic               EV_VALID,
    input  logic               EV_READY,
    output logic [3:0]         EV_CX,
    output logic [3:0]         EV_CY,
    output logic [BATCH_W-1:0] EV_BATCH,
    output logic               EV_LAST,
    output logic               CMP_VALID,
    output logic [3:0]         CMP_CX,
    output logic [3:0]         CMP_CY,
    output logic               ITER_END,
    output logic [ITER_W-1:0]  ITER_IDX,
    output logic               DONE
);

    state_t              state;
    state_t              nxt;
    logic [BATCH_W-1:0]  batch;
    logic [DRAIN_W-1:0]  drain;
    ptr_t                ptr;
    logic [ITER_W-1:0]   iter;
    logic                at_end;
    logic                last_iter;
    logic                last_b;
    logic                abort_act;
    logic                start_acc;
    logic                xfer;
    logic                step;
    logic                restart;

    assign last_b    = (batch == BATCH_W'(NUM_BATCH - 1));
    assign abort_act = ABORT && (state != S_IDLE);
    assign start_acc = START && (state == S_IDLE);
    assign xfer      = (state == S_ISSUE) && EV_READY && !ABORT;
    assign step      = (state == S_NEXT) && !ABORT;
    assign restart   = start_acc || abort_act;

    laser_scan_ptr u_ptr (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .step      (step),
        .restart   (restart),
        .ptr       (ptr),
        .iter      (iter),
        .at_end    (at_end),
        .last_iter (last_iter)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state <= S_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (abort_act) begin
            nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (START) nxt = S_ISSUE;
                S_ISSUE:  if (EV_READY && last_b) nxt = S_WAIT;
                S_WAIT:   if (drain <= DRAIN_W'(1)) nxt = S_CMP;
                S_CMP:    nxt = S_NEXT;
                S_NEXT:   nxt = (at_end && last_iter) ? S_FINISH : S_ISSUE;
                S_FINISH: nxt = S_IDLE;
                default:  nxt = S_IDLE;
            endcase
        end
    end

    // Batch index and result-drain counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            batch <= '0;
            drain <= '0;
        end else if (restart) begin
            batch <= '0;
            drain <= '0;
        end else begin
            if (xfer && !last_b)
                batch <= batch + 1'b1;
            else if (step)
                batch <= '0;
            if (xfer && last_b)
                drain <= DRAIN_W'(RES_LAT);
            else if (state == S_WAIT)
                drain <= drain - 1'b1;
        end
    end

    always_comb begin
        BUSY      = (state != S_IDLE);
        EV_VALID  = (state == S_ISSUE) && !ABORT;
        EV_CX     = ptr.x;
        EV_CY     = ptr.y;
        EV_BATCH  = batch;
        EV_LAST   = (state == S_ISSUE) && last_b;
        CMP_VALID = (state == S_CMP) && !ABORT;
        CMP_CX    = ptr.x;
        CMP_CY    = ptr.y;
        ITER_END  = (state == S_NEXT) && at_end && !ABORT;
        ITER_IDX  = iter;
        DONE      = (state == S_FINISH) && !ABORT;
    end

endmodule

// File: tb/tb_laser_scan_sched.sv
// Self-checking bench for laser_scan_sched: stall table, corner
// sequences, and a full serpentine scan against a candidate scoreboard.
module tb_laser_scan_sched;

    logic       CLK;
    logic       RST_N;
    logic       START;
    logic       ABORT;
    logic       BUSY;
    logic       EV_VALID;
    logic       EV_READY;
    logic [3:0] EV_CX;
    logic [3:0] EV_CY;
    logic [3:0] EV_BATCH;
    logic       EV_LAST;
    logic       CMP_VALID;
    logic [3:0] CMP_CX;
    logic [3:0] CMP_CY;
    logic       ITER_END;
    logic [2:0] ITER_IDX;
    logic       DONE;

    laser_scan_sched dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .ABORT     (ABORT),
        .BUSY      (BUSY),
        .EV_VALID  (EV_VALID),
        .EV_READY  (EV_READY),
        .EV_CX     (EV_CX),
        .EV_CY     (EV_CY),
        .EV_BATCH  (EV_BATCH),
        .EV_LAST   (EV_LAST),
        .CMP_VALID (CMP_VALID),
        .CMP_CX    (CMP_CX),
        .CMP_CY    (CMP_CY),
        .ITER_END  (ITER_END),
        .ITER_IDX  (ITER_IDX),
        .DONE      (DONE)
    );

    typedef struct {
        logic [7:0] p;
        logic [2:0] it;
    } exp_t;

    typedef struct {
        int sb;
        int sl;
        int exp_cmp;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_iter_end = 0;
    int n_done = 0;
    int t_done = 0;
    int t_iter0 = 0;

    logic        prev_v = 1'b0;
    logic [12:0] prev_pay = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // One cycle: sample outputs at negedge, score compares and handshake.
    task automatic tick();
        exp_t e;
        logic in_ready;
        logic in_abort;
        in_ready = EV_READY;
        in_abort = ABORT;
        @(negedge CLK);
        if (prev_v && !in_ready && !in_abort) begin
            check("hold_valid", 32'(EV_VALID), 1);
            check("hold_payload", 32'({EV_CX, EV_CY, EV_BATCH, EV_LAST}),
                  32'(prev_pay));
        end
        if (EV_VALID)
            check("ev_last", 32'(EV_LAST), 32'(EV_BATCH == 4'd9));
        if (CMP_VALID) begin
            if (exp_q.size() == 0) begin
                check("cmp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("cmp_ptr", 32'({CMP_CY, CMP_CX}), 32'(e.p));
                check("cmp_iter", 32'(ITER_IDX), 32'(e.it));
            end
        end
        if (ITER_END) begin
            if (n_iter_end == 0)
                t_iter0 = cyc;
            n_iter_end++;
        end
        if (DONE) begin
            n_done++;
            t_done = cyc;
        end
        prev_v = EV_VALID;
        prev_pay = {EV_CX, EV_CY, EV_BATCH, EV_LAST};
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        EV_READY = 1'b1;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        exp_q.delete();
        n_iter_end = 0;
        n_done = 0;
    endtask

    task automatic do_start(output int t);
        t = cyc;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic abort_clear();
        ABORT = 1'b1;
        tick();
        check("abort_idle", 32'(BUSY), 0);
        ABORT = 1'b0;
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    int t;
    int t2;
    int tc;
    int tcs[3];
    int ncmp;
    int stalls;
    bit got;

    initial begin
        vecs[0] = '{sb: 0, sl: 0, exp_cmp: 12};
        vecs[1] = '{sb: 4, sl: 3, exp_cmp: 15};
        vecs[2] = '{sb: 9, sl: 2, exp_cmp: 14};
        vecs[3] = '{sb: 0, sl: 1, exp_cmp: 13};

        RST_N = 1'b0;
        START = 1'b0;
        ABORT = 1'b0;
        EV_READY = 1'b1;
        #1;
        check("reset_outs", 32'({BUSY, EV_VALID, EV_CX, EV_CY, EV_BATCH,
              EV_LAST, CMP_VALID, CMP_CX, CMP_CY, ITER_END, ITER_IDX,
              DONE}), 0);
        do_reset();
        check("idle_busy", 32'(BUSY), 0);

        // Stall table: first candidate latency with EV_READY held low.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            exp_q.push_back('{p: 8'h00, it: 3'd0});
            do_start(t);
            check("ev_first", 32'({EV_VALID, EV_BATCH}), 32'({1'b1, 4'd0}));
            stalls = 0;
            got = 0;
            tc = 0;
            for (int n = 0; n < 60 && !got; n++) begin
                EV_READY = !(EV_VALID && EV_BATCH == 4'(vecs[i].sb) &&
                             stalls < vecs[i].sl);
                if (!EV_READY)
                    stalls++;
                tick();
                if (CMP_VALID) begin
                    got = 1;
                    tc = cyc;
                end
            end
            EV_READY = 1'b1;
            check("cmp_seen", 32'(got), 1);
            check("cmp_lat", tc - t, vecs[i].exp_cmp);
            abort_clear();
        end

        // Two candidates back to back.
        do_reset();
        exp_q.push_back('{p: 8'h00, it: 3'd0});
        exp_q.push_back('{p: 8'h01, it: 3'd0});
        do_start(t);
        ncmp = 0;
        for (int n = 0; n < 60 && ncmp < 2; n++) begin
            tick();
            if (CMP_VALID) begin
                tcs[ncmp] = cyc;
                ncmp++;
            end
        end
        check("two_cmp", ncmp, 2);
        check("cmp0_t", tcs[0] - t, 12);
        check("cmp1_t", tcs[1] - t, 25);
        abort_clear();

        // Second START during ISSUE is ignored.
        do_reset();
        exp_q.push_back('{p: 8'h00, it: 3'd0});
        exp_q.push_back('{p: 8'h01, it: 3'd0});
        exp_q.push_back('{p: 8'h02, it: 3'd0});
        do_start(t);
        ncmp = 0;
        for (int n = 0; n < 80 && ncmp < 3; n++) begin
            START = (cyc == t + 3);
            tick();
            if (CMP_VALID) begin
                tcs[ncmp] = cyc;
                ncmp++;
            end
        end
        START = 1'b0;
        check("restart_cmp", ncmp, 3);
        check("restart_t", tcs[2] - t, 38);
        abort_clear();

        // ABORT in WAIT, then START two cycles later.
        do_reset();
        do_start(t);
        for (int n = 0; n < 40 && cyc < t + 11; n++)
            tick();
        check("in_wait", 32'({EV_VALID, BUSY}), 32'({1'b0, 1'b1}));
        ABORT = 1'b1;
        tick();
        check("abort_wait", 32'({BUSY, CMP_VALID}), 0);
        ABORT = 1'b0;
        tick();
        exp_q.push_back('{p: 8'h00, it: 3'd0});
        do_start(t2);
        check("restart_gap", t2 - t, 13);
        check("restart_pay", 32'({EV_VALID, EV_CY, EV_CX, EV_BATCH, ITER_IDX}),
              32'({1'b1, 15'd0}));
        got = 0;
        tc = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (CMP_VALID) begin
                got = 1;
                tc = cyc;
            end
        end
        check("restart_cmp_t", tc - t2, 12);
        abort_clear();

        // ABORT during ISSUE drops EV_VALID combinationally.
        do_reset();
        do_start(t);
        tick();
        tick();
        check("issue_valid", 32'(EV_VALID), 1);
        ABORT = 1'b1;
        #1;
        check("abort_drop", 32'(EV_VALID), 0);
        tick();
        check("abort_issue_idle", 32'(BUSY), 0);
        ABORT = 1'b0;

        // Reset mid-ISSUE: outputs clear at once, no DONE follows.
        do_reset();
        do_start(t);
        for (int n = 0; n < 4; n++)
            tick();
        check("mid_batch", 32'(EV_BATCH), 4);
        RST_N = 1'b0;
        #1;
        check("rst_outs", 32'({BUSY, EV_VALID, EV_CX, EV_CY, EV_BATCH,
              EV_LAST, CMP_VALID, CMP_CX, CMP_CY, ITER_END, ITER_IDX,
              DONE}), 0);
        tick();
        tick();
        RST_N = 1'b1;
        for (int n = 0; n < 40; n++)
            tick();
        check("rst_no_done", n_done, 0);
        check("rst_idle", 32'(BUSY), 0);

        // Full serpentine scan.
        do_reset();
        for (int it = 0; it < 6; it++)
            for (int k = 0; k < 256; k++)
                exp_q.push_back('{p: (it % 2 == 0) ? 8'(k) : 8'(255 - k),
                                  it: 3'(it)});
        do_start(t);
        got = 0;
        for (int n = 0; n < 20100 && !got; n++) begin
            tick();
            if (DONE)
                got = 1;
        end
        check("scan_done_seen", 32'(got), 1);
        check("scan_done_t", t_done - t, 19969);
        check("scan_iter_end", n_iter_end, 6);
        check("scan_iter0_t", t_iter0 - t, 3328);
        tick();
        check("scan_done_once", n_done, 1);
        check("scan_busy_low", 32'(BUSY), 0);
        check("scan_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
